spi_bus_bridge: RTL and testbench
=================================

# spi_bus_bridge

Converts the decoded frame fields of the SPI data path (`addr`, `status`, `wdata`, `address_ready`, `data_ready`) into single-word read/write transfers on the internal register/memory bus of the crypto accelerator. It returns read data on `rdata` to the data path, which loads it into its MISO shift register. It supports single and burst frames with auto-incrementing address, a bounded bus wait with timeout, and chip-select abort. It sits directly downstream of the SPI data path and upstream of the accelerator register bank.

## Interface
- `ADDR_W`, default 20: bus address width; must match the data path `addr` width.
- `DATA_W`, default 16: bus data width.
- `TIMEOUT`, default 255: maximum number of clk cycles `bus_req` is held waiting for `bus_ack`; minimum value 1.

- `clk` in 1: single system clock; all logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cs_n` in 1: raw SPI chip select (data path `cs_n_o`); asynchronous, synchronised internally with 2 flops.
- `address_ready` in 1: one-cycle pulse; `addr` and `status` are valid.
- `data_ready` in 1: one-cycle pulse; end of data phase, and `wdata` is valid.
- `addr` in ADDR_W: frame start address.
- `status` in 4: bit 2 = write (1) or read (0); bit 1 = burst; bits 3 and 0 are ignored.
- `wdata` in DATA_W: write data from the data path.
- `rdata` out DATA_W: read data to the data path.
- `bus_req` out 1: transfer request.
- `bus_we` out 1: 1 = write.
- `bus_addr` out ADDR_W: transfer address.
- `bus_wdata` out DATA_W: transfer write data.
- `bus_ack` in 1: transfer complete; `bus_rdata` is valid in the same cycle.
- `bus_rdata` in DATA_W: bus read data.
- `busy` out 1: high in any state other than IDLE.
- `bus_err` out 1: sticky timeout flag; cleared on the next accepted `address_ready`.

## Operation
- Reset values: all outputs 0; state IDLE; internal address, write, and burst latches 0.
- **IDLE**
  - On `address_ready` with synchronised `cs_n` low: latch `addr` into `addr_q`, `status[2]` into `we_q`, `status[1]` into `burst_q`; clear `bus_err`.
  - Go to RD if `we_q` = 0, otherwise go to WAIT_WD.
- **RD**
  - `bus_req`=1, `bus_we`=0, `bus_addr`=`addr_q`.
  - On `bus_ack`: `rdata` <= `bus_rdata`; go to WAIT_NEXT.
- **WAIT_WD**
  - Wait for `data_ready`.
  - Then `bus_wdata` <= `wdata`; go to WR.
- **WR**
  - `bus_req`=1, `bus_we`=1, `bus_addr`=`addr_q`.
  - On `bus_ack`: go to WAIT_NEXT if `burst_q`, otherwise go to IDLE.
- **WAIT_NEXT**
  - Read, non-burst: on `data_ready`, go to IDLE.
  - Burst read: on `data_ready`, `addr_q` <= `addr_q`+1; go to RD.
  - Burst write: `addr_q` <= `addr_q`+1 immediately; go to WAIT_WD.
- **Address increment:** modulo 2^ADDR_W, so the all-ones address wraps to 0 with no flag.
- **Timeout:**
  - A cycle counter runs while `bus_req` is high.
  - When it reaches TIMEOUT without `bus_ack`: drop `bus_req` and set `bus_err`.
  - If the transfer was a read, `rdata` <= all-ones.
  - Then continue exactly as if `bus_ack` had been received.
- **cs_n high (synchronised):**
  - In RD or WR: the outstanding transfer completes (ack or timeout), then the block goes to IDLE regardless of `burst_q`.
  - In any other state: go to IDLE on the next cycle.
- **Simultaneous `address_ready` and `cs_n` high:** `cs_n` wins; the pulse is ignored.
- **`address_ready` outside IDLE:** ignored.
- **`data_ready` in RD or WR:** ignored.

## Timing
- `bus_req` rises 1 cycle after `address_ready` (read) or after `data_ready` (write).
- `bus_addr`, `bus_we`, and `bus_wdata` are registered and stable for the whole time `bus_req` is high.
- **Handshake:**
  - `bus_ack` is sampled only while `bus_req`=1.
  - `bus_req` falls in the cycle after `bus_ack` is sampled.
  - `bus_req` stays low for at least 1 cycle between consecutive transfers.
  - `bus_ack` while `bus_req`=0 is ignored.
- `rdata` updates in the cycle after `bus_ack` and holds until the next read completion or reset.
- **Read latency budget:** `address_ready` → `rdata` valid = 2 + bus latency cycles. It must be shorter than the data path interval from `cnt`=24 to the capture at `cnt`=32; in 4-bit mode that interval is 2 sclk periods.
- **Reset mid-transfer:** `bus_req` drops asynchronously; no completion is reported.

## Test plan
- **Single read:** `addr`=20'h00012, `status`=4'b0000, bus acks after 3 cycles with 16'hA5C3 → one request with `bus_addr`=20'h00012 and `bus_we`=0; `rdata`=16'hA5C3; `busy` low after `data_ready`.
- **Single write:** `addr`=20'h00100, `status`=4'b0100, `wdata`=16'h1234 → exactly one write to 20'h00100 with `bus_wdata`=16'h1234, issued 1 cycle after `data_ready`.
- **Burst write with wrap:** `addr`=20'hFFFFF, `status`=4'b0110, 3 words (16'h0001, 16'h0002, 16'h0003) → writes to 20'hFFFFF, 20'h00000, 20'h00001 in that order.
- **Timeout:** read with `bus_ack` held low → `bus_req` high for exactly 255 cycles; then `bus_err`=1 and `rdata`=16'hFFFF; `bus_err` clears on the next `address_ready`.
- **cs_n abort:** burst read, `cs_n` raised while in RD with ack 5 cycles later → transfer completes, block returns to IDLE, and no further `bus_req` is issued.
- **Reset mid-RD:** `reset_n` low while in RD → `bus_req`, `busy`, and `rdata` are all 0 immediately.

Source files
------------

// File: rtl/spi_bus_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_bus_bridge_if
// Brief    : SPI frame fields and register bus handshake for spi_bus_bridge.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_bus_bridge_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              cs_n;
    logic              address_ready;
    logic              data_ready;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        status;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;
    logic              busy;
    logic              bus_err;

    // Bridge view: consumes frame fields and bus responses.
    modport slave (
        input  cs_n, address_ready, data_ready, addr, status, wdata,
        input  bus_ack, bus_rdata,
        output rdata, bus_req, bus_we, bus_addr, bus_wdata, busy, bus_err
    );

    // Environment view: SPI data path plus register bank.
    modport master (
        output cs_n, address_ready, data_ready, addr, status, wdata,
        output bus_ack, bus_rdata,
        input  rdata, bus_req, bus_we, bus_addr, bus_wdata, busy, bus_err
    );
endinterface
`default_nettype wire

// File: rtl/spi_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : spi_bus_bridge
// Brief    : Turns decoded SPI frames into single/burst register bus transfers.
// Revision : 1.0 - initial release
// ============================================================================
module spi_bus_bridge #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    spi_bus_bridge_if.slave   bif
);
    localparam int              TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RD        = 3'd1;
    localparam logic [2:0] S_WAIT_WD   = 3'd2;
    localparam logic [2:0] S_WR        = 3'd3;
    localparam logic [2:0] S_WAIT_NEXT = 3'd4;

    logic [2:0]        state, state_nxt;
    logic              cs_meta, cs_sync;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q, burst_q;
    logic [TW-1:0]     tcnt;
    logic [DATA_W-1:0] rdata_q, wdata_q;
    logic              err_q;
    logic              req, busy_w;
    logic              accept, tmo_hit, xfer_done, addr_inc;
    logic              unused_status;

    assign unused_status = bif.status[3] ^ bif.status[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_meta <= 1'b1;
            cs_sync <= 1'b1;
        end else begin
            cs_meta <= bif.cs_n;
            cs_sync <= cs_meta;
        end
    end

    assign accept    = (state == S_IDLE) && bif.address_ready && !cs_sync;
    assign tmo_hit   = req && !bif.bus_ack && (tcnt == TMO_LAST);
    assign xfer_done = req && (bif.bus_ack || tmo_hit);
    // Burst writes advance as soon as the previous word lands; burst reads wait for the data path.
    assign addr_inc  = (state == S_WAIT_NEXT) && !cs_sync &&
                       (we_q || (bif.data_ready && burst_q));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = bif.status[2] ? S_WAIT_WD : S_RD;
            end
            S_RD: begin
                if (xfer_done) state_nxt = cs_sync ? S_IDLE : S_WAIT_NEXT;
            end
            S_WAIT_WD: begin
                if (cs_sync)             state_nxt = S_IDLE;
                else if (bif.data_ready) state_nxt = S_WR;
            end
            S_WR: begin
                if (xfer_done) state_nxt = (cs_sync || !burst_q) ? S_IDLE : S_WAIT_NEXT;
            end
            S_WAIT_NEXT: begin
                if (cs_sync)             state_nxt = S_IDLE;
                else if (we_q)           state_nxt = S_WAIT_WD;
                else if (bif.data_ready) state_nxt = burst_q ? S_RD : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req    = 1'b0;
        busy_w = 1'b1;
        case (state)
            S_IDLE:       busy_w = 1'b0;
            S_RD, S_WR:   req    = 1'b1;
            default:      req    = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            burst_q <= 1'b0;
            tcnt    <= '0;
            rdata_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= bif.addr;
                we_q    <= bif.status[2];
                burst_q <= bif.status[1];
                err_q   <= 1'b0;
            end else if (addr_inc) begin
                addr_q  <= addr_q + 1'b1;
            end

            if (req && !xfer_done) tcnt <= tcnt + 1'b1;
            else                   tcnt <= '0;

            if (tmo_hit) err_q <= 1'b1;

            if (state == S_RD) begin
                if (bif.bus_ack)  rdata_q <= bif.bus_rdata;
                else if (tmo_hit) rdata_q <= '1;
            end

            if ((state == S_WAIT_WD) && bif.data_ready && !cs_sync)
                wdata_q <= bif.wdata;
        end
    end

    assign bif.rdata     = rdata_q;
    assign bif.bus_req   = req;
    assign bif.bus_we    = we_q;
    assign bif.bus_addr  = addr_q;
    assign bif.bus_wdata = wdata_q;
    assign bif.busy      = busy_w;
    assign bif.bus_err   = err_q;
endmodule
`default_nettype wire

// File: tb/tb_spi_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_bus_bridge
// Brief    : Directed bench with a bus-transfer scoreboard for spi_bus_bridge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_bus_bridge;
    typedef struct {
        logic        we;
        logic [19:0] addr;
        logic [15:0] wdata;
    } xfer_t;

    logic clk = 1'b0;
    logic reset_n;

    int checks   = 0;
    int failures = 0;
    int req_cnt  = 0;
    int done_cnt = 0;
    int last_len = 0;
    int cyc      = 0;
    int ack_lat  = 3;
    int nd       = 0;
    bit in_req   = 1'b0;
    logic [15:0] rd_val = 16'h0;
    logic [19:0] start_addr;
    xfer_t exp_q[$];
    xfer_t e;

    spi_bus_bridge_if #(.ADDR_W(20), .DATA_W(16)) bif ();

    spi_bus_bridge #(.ADDR_W(20), .DATA_W(16), .TIMEOUT(255)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bif     (bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic we, input logic [19:0] a, input logic [15:0] d);
        xfer_t x;
        x.we = we; x.addr = a; x.wdata = d;
        exp_q.push_back(x);
    endtask

    task automatic pulse_addr(input logic [19:0] a, input logic [3:0] st);
        tick();
        bif.addr = a; bif.status = st; bif.address_ready = 1'b1;
        tick();
        bif.address_ready = 1'b0;
    endtask

    task automatic pulse_data(input logic [15:0] d);
        tick();
        bif.wdata = d; bif.data_ready = 1'b1;
        tick();
        bif.data_ready = 1'b0;
    endtask

    task automatic wait_done(input int tgt);
        int n = 0;
        while (done_cnt < tgt && n < 1000) begin
            tick();
            n++;
        end
        chk("wait_done", done_cnt >= tgt, 1);
    endtask

    // Register-bank model: acks after ack_lat request cycles (0 = never).
    initial begin
        bif.bus_ack = 1'b0;
        bif.bus_rdata = 16'h0;
        forever begin
            @(negedge clk);
            if (bif.bus_req) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    cyc = 0;
                    start_addr = bif.bus_addr;
                    req_cnt++;
                    chk("req_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("req_we", bif.bus_we, e.we);
                        chk("req_addr", bif.bus_addr, e.addr);
                        if (e.we) chk("req_wdata", bif.bus_wdata, e.wdata);
                    end
                end else begin
                    chk("addr_stable", bif.bus_addr, start_addr);
                end
                cyc++;
                bif.bus_ack = (ack_lat != 0) && (cyc == ack_lat);
                bif.bus_rdata = rd_val;
            end else begin
                if (in_req) begin
                    in_req = 1'b0;
                    done_cnt++;
                    last_len = cyc;
                end
                bif.bus_ack = 1'b0;
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        bif.cs_n = 1'b1; bif.address_ready = 1'b0; bif.data_ready = 1'b0;
        bif.addr = '0; bif.status = '0; bif.wdata = '0;
        #12;
        chk("rst_bus_req", bif.bus_req, 0);
        chk("rst_busy", bif.busy, 0);
        chk("rst_rdata", bif.rdata, 0);
        chk("rst_bus_err", bif.bus_err, 0);
        chk("rst_bus_addr", bif.bus_addr, 0);
        tick();
        reset_n = 1'b1;
        bif.cs_n = 1'b0;
        repeat (3) tick();

        // Single read
        ack_lat = 3; rd_val = 16'hA5C3;
        push(1'b0, 20'h00012, 16'h0);
        pulse_addr(20'h00012, 4'b0000);
        wait_done(++nd);
        chk("rd_len", last_len, 3);
        chk("rd_rdata", bif.rdata, 16'hA5C3);
        chk("rd_busy_wait", bif.busy, 1);
        pulse_data(16'h0);
        chk("rd_busy_end", bif.busy, 0);

        // Single write
        ack_lat = 2;
        push(1'b1, 20'h00100, 16'h1234);
        pulse_addr(20'h00100, 4'b0100);
        repeat (2) tick();
        chk("wr_no_early_req", req_cnt, 1);
        pulse_data(16'h1234);
        @(negedge clk);
        chk("wr_latency", bif.bus_req, 1);
        wait_done(++nd);
        tick();
        chk("wr_busy_end", bif.busy, 0);
        chk("wr_count", req_cnt, 2);

        // Burst write across the address wrap
        ack_lat = 1;
        push(1'b1, 20'hFFFFF, 16'h0001);
        push(1'b1, 20'h00000, 16'h0002);
        push(1'b1, 20'h00001, 16'h0003);
        pulse_addr(20'hFFFFF, 4'b0110);
        for (int i = 1; i <= 3; i++) begin
            pulse_data(16'(i));
            wait_done(++nd);
        end
        bif.cs_n = 1'b1;
        repeat (4) tick();
        chk("bw_busy_end", bif.busy, 0);
        chk("bw_count", req_cnt, 5);
        bif.cs_n = 1'b0;
        repeat (3) tick();

        // Timeout on a read
        ack_lat = 0;
        push(1'b0, 20'h00055, 16'h0);
        pulse_addr(20'h00055, 4'b0000);
        wait_done(++nd);
        chk("tmo_len", last_len, 255);
        chk("tmo_err", bif.bus_err, 1);
        chk("tmo_rdata", bif.rdata, 16'hFFFF);
        pulse_data(16'h0);
        ack_lat = 1; rd_val = 16'h0F0F;
        push(1'b0, 20'h00056, 16'h0);
        pulse_addr(20'h00056, 4'b0000);
        chk("tmo_err_clear", bif.bus_err, 0);
        wait_done(++nd);
        chk("tmo_next_rdata", bif.rdata, 16'h0F0F);
        pulse_data(16'h0);

        // cs_n abort during a burst read
        ack_lat = 6; rd_val = 16'hBEEF;
        push(1'b0, 20'h00200, 16'h0);
        pulse_addr(20'h00200, 4'b0010);
        tick();
        bif.cs_n = 1'b1;
        wait_done(++nd);
        chk("abort_len", last_len, 6);
        repeat (10) tick();
        chk("abort_busy", bif.busy, 0);
        chk("abort_rdata", bif.rdata, 16'hBEEF);
        chk("abort_count", req_cnt, 8);
        bif.cs_n = 1'b0;
        repeat (3) tick();

        // Reset while a read is outstanding
        ack_lat = 0;
        push(1'b0, 20'h00300, 16'h0);
        pulse_addr(20'h00300, 4'b0000);
        repeat (2) tick();
        chk("pre_rst_req", bif.bus_req, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_req", bif.bus_req, 0);
        chk("mid_rst_busy", bif.busy, 0);
        chk("mid_rst_rdata", bif.rdata, 0);
        tick();
        reset_n = 1'b1;
        repeat (5) tick();
        chk("final_count", req_cnt, 9);
        chk("final_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
